ps2_key_ctrl: RTL

//  Sequences the byte stream from the PS/2 receiver (Set-2 scancodes) into navigation commands.

---
 rtl/ps2_key_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns the PS/2 Set-2 byte stream into navigation commands
// and keeps a one-hot 2x2 quadrant selection.
// Handles E0/F0 prefixes, drops stale prefixes after TIMEOUT_CYCLES idle
// clocks, and tracks the held key so typematic repeats can be recognised.
// Optional build macro PS2_KEY_CTRL_REPEAT_EN: when defined, a repeated make
// of the held key re-issues its command. When undefined, repeats are silent.
`timescale 1ns/1ps

module ps2_key_ctrl #(
  parameter int TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [3:0] quadrant,
  output logic       key_held
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_UP    = 3'd3;
  localparam logic [2:0] CMD_DOWN  = 3'd4;
  localparam logic [2:0] CMD_ENTER = 3'd5;
  localparam logic [2:0] CMD_ESC   = 3'd6;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BREAK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BREAK,
    S_EXT_BREAK
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_hit;

  // Decode results for the byte strobed this cycle.
  logic             mk_fire_p0;
  logic             brk_fire_p0;
  logic             ext_p0;
  logic             is_rep_p0;
  logic             brk_match_p0;
  logic [2:0]       map_p0;
  logic             emit_p0;

  logic             held_ext_q;
  logic [7:0]       held_code_q;

  // Receiver housekeeping bytes (ACK, BAT, echo, resend, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    logic r;
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: r = 1'b1;
      default:                                  r = 1'b0;
    endcase
    return r;
  endfunction

  // Keypad and E0 arrow variants share the same scancode byte, so the
  // extended flag plays no part in the mapping.
  function automatic logic [2:0] map_code(input logic [7:0] b);
    logic [2:0] c;
    case (b)
      8'h6B:   c = CMD_LEFT;
      8'h74:   c = CMD_RIGHT;
      8'h75:   c = CMD_UP;
      8'h72:   c = CMD_DOWN;
      8'h5A:   c = CMD_ENTER;
      8'h76:   c = CMD_ESC;
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

  // A corrupted selection collapses to TL so the output stays one-hot.
  function automatic logic [1:0] quad_to_idx(input logic [3:0] q);
    logic [1:0] idx;
    case (q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Saturating move: idx[0] is the column, idx[1] the row; edges do not wrap.
  function automatic logic [3:0] move_quad(input logic [3:0] q, input logic [2:0] c);
    logic [1:0] idx;
    idx = quad_to_idx(q);
    case (c)
      CMD_LEFT:  idx[0] = 1'b0;
      CMD_RIGHT: idx[0] = 1'b1;
      CMD_UP:    idx[1] = 1'b0;
      CMD_DOWN:  idx[1] = 1'b1;
      CMD_ESC:   idx    = 2'd0;
      default:   idx    = idx;
    endcase
    return 4'b0001 << idx;
  endfunction

  // A prefix expires only on a cycle with no incoming byte.
  assign tmo_hit = (state_q != S_IDLE) && !rx_valid && (tmo_cnt_q == CNT_LAST);

  // Next-state and per-byte decode.
  always_comb begin
    state_d     = state_q;
    mk_fire_p0  = 1'b0;
    brk_fire_p0 = 1'b0;
    ext_p0      = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte == BYTE_EXT) begin
            state_d = S_EXT;
          end else if (rx_byte == BYTE_BREAK) begin
            state_d = S_BREAK;
          end else if (!is_ignored(rx_byte)) begin
            mk_fire_p0 = 1'b1;
          end
        end
        S_EXT: begin
          if (rx_byte == BYTE_BREAK) begin
            state_d = S_EXT_BREAK;
          end else if (rx_byte == BYTE_EXT) begin
            state_d = S_EXT;
          end else begin
            mk_fire_p0 = 1'b1;
            ext_p0     = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_BREAK: begin
          brk_fire_p0 = 1'b1;
          state_d     = S_IDLE;
        end
        S_EXT_BREAK: begin
          brk_fire_p0 = 1'b1;
          ext_p0      = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
    end
  end

  assign map_p0       = map_code(rx_byte);
  assign is_rep_p0    = key_held && ({ext_p0, rx_byte} == {held_ext_q, held_code_q});
  assign brk_match_p0 = ({ext_p0, rx_byte} == {held_ext_q, held_code_q});

`ifdef PS2_KEY_CTRL_REPEAT_EN
  assign emit_p0 = mk_fire_p0 && (map_p0 != CMD_NONE);
`else
  assign emit_p0 = mk_fire_p0 && (map_p0 != CMD_NONE) && !is_rep_p0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Prefix age counter: restarts on every byte, runs only while a prefix waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (rx_valid || (state_q == S_IDLE) || tmo_hit) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Held-key tracking; a repeat of the held key never changes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      key_held    <= 1'b0;
    end else if (mk_fire_p0 && !is_rep_p0) begin
      held_ext_q  <= ext_p0;
      held_code_q <= rx_byte;
      key_held    <= 1'b1;
    end else if (brk_fire_p0 && brk_match_p0) begin
      key_held    <= 1'b0;
    end
  end

  // ---- stage boundary: decoded byte -> registered command and quadrant ----
  // Command strobe and quadrant move land on the same clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
      quadrant  <= 4'b0001;
    end else begin
      cmd_valid <= emit_p0;
      cmd_code  <= emit_p0 ? map_p0 : CMD_NONE;
      if (emit_p0) quadrant <= move_quad(quadrant, map_p0);
    end
  end

endmodule
